// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - funct codes, FSM states and decode helpers for muldiv_unit
// Shared by muldiv_unit and its testbench. No ports.
package muldiv_unit_pkg;

    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

    // 0100xx (move) and 0110xx (mul/div) form the HILO class.
    function automatic logic is_hilo(input logic [5:0] f);
        return (f[5:4] == 2'b01) && (f[2] == 1'b0);
    endfunction

    function automatic logic is_muldiv(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

    // Within the mul/div group bit 1 selects divide, bit 0 selects unsigned.
    function automatic logic is_div_code(input logic [5:0] f);
        return f[5:1] == 5'b01101;
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - conditional two's-complement negation (abs on entry, sign apply in FIX)
// Ports: val - input magnitude/value, neg - negate when high, res - conditioned result.
module muldiv_sign_fix #(
    parameter int N = 32
) (
    input  logic [N-1:0] val,
    input  logic         neg,
    output logic [N-1:0] res
);

    assign res = neg ? -val : val;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS multiply/divide unit with HI/LO registers
// Ports: clk_I clock, rst_I async active-high reset, Start_I/Func_I/A_I/B_I instruction
// from EX, Busy_O sequence running, Stall_O hold EX, Done_O result pulse, Hi_O/Lo_O registers.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiply, MULT/MULTU go IDLE->FIX directly.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_I,
    input  logic             rst_I,
    input  logic             Start_I,
    input  logic [5:0]       Func_I,
    input  logic [WIDTH-1:0] A_I,
    input  logic [WIDTH-1:0] B_I,
    output logic             Busy_O,
    output logic             Stall_O,
    output logic             Done_O,
    output logic [WIDTH-1:0] Hi_O,
    output logic [WIDTH-1:0] Lo_O
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state, state_n;
    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   dvsr;
    logic [CW-1:0]      cnt;
    logic               is_div, neg_q, neg_r, done;
    logic [WIDTH-1:0]   hi, lo;

    logic               accept, op_signed, sign_a, sign_b;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_rem;
    logic               div_ok;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign accept    = Start_I && (state == MD_IDLE) && is_muldiv(Func_I);
    assign op_signed = ~Func_I[0];
    assign sign_a    = op_signed & A_I[WIDTH-1];
    assign sign_b    = op_signed & B_I[WIDTH-1];

    muldiv_sign_fix #(.N(WIDTH)) u_abs_a (.val(A_I), .neg(sign_a), .res(a_mag));
    muldiv_sign_fix #(.N(WIDTH)) u_abs_b (.val(B_I), .neg(sign_b), .res(b_mag));

    muldiv_sign_fix #(.N(2*WIDTH)) u_fix_prod (.val(acc), .neg(neg_q), .res(prod_fix));
    muldiv_sign_fix #(.N(WIDTH)) u_fix_quo (.val(acc[WIDTH-1:0]), .neg(neg_q), .res(quo_fix));
    muldiv_sign_fix #(.N(WIDTH)) u_fix_rem (.val(acc[2*WIDTH-1:WIDTH]), .neg(neg_r), .res(rem_fix));

    always_comb begin
        // Shift-add: add multiplicand when multiplier LSB is set, then shift right.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvsr} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        // Restoring divide: remainder < divisor, so the difference always fits WIDTH bits.
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_ok    = div_shift >= {1'b0, dvsr};
        div_rem   = div_shift[WIDTH-1:0] - dvsr;
        div_next  = div_ok ? {div_rem, acc[WIDTH-2:0], 1'b1}
                           : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        state_n = state;
        case (state)
            MD_IDLE: begin
                if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_n = is_div_code(Func_I) ? MD_RUN : MD_FIX;
`else
                    state_n = MD_RUN;
`endif
                end
            end
            MD_RUN:  if (cnt == '0) state_n = MD_FIX;
            MD_FIX:  state_n = MD_IDLE;
            default: state_n = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk_I or posedge rst_I) begin
        if (rst_I) state <= MD_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk_I or posedge rst_I) begin
        if (rst_I) begin
            acc    <= '0;
            dvsr   <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= (state == MD_FIX);
            case (state)
                MD_IDLE: begin
                    if (accept) begin
                        dvsr   <= b_mag;
                        cnt    <= CW'(WIDTH - 1);
                        is_div <= is_div_code(Func_I);
                        // A zero divisor keeps the all-ones quotient unsigned-looking.
                        neg_q  <= (sign_a ^ sign_b) && !(is_div_code(Func_I) && (B_I == '0));
                        neg_r  <= sign_a;
                        acc    <= {{WIDTH{1'b0}}, a_mag};
`ifdef MULDIV_FAST_MUL_EN
                        if (!is_div_code(Func_I))
                            acc <= {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif
                    end else if (Start_I && (Func_I == FUNC_MTHI)) begin
                        hi <= A_I;
                    end else if (Start_I && (Func_I == FUNC_MTLO)) begin
                        lo <= A_I;
                    end
                end
                MD_RUN: begin
                    cnt <= cnt - 1'b1;
                    acc <= is_div ? div_next : mul_next;
                end
                MD_FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy_O  = (state != MD_IDLE);
    assign Stall_O = Start_I && Busy_O && is_hilo(Func_I);
    assign Done_O  = done;
    assign Hi_O    = hi;
    assign Lo_O    = lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (WIDTH = 32)
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam logic [5:0] FUNC_ADD = 6'b100000;

    logic        clk = 1'b0;
    logic        rst_I, Start_I;
    logic [5:0]  Func_I;
    logic [31:0] A_I, B_I;
    logic        Busy_O, Stall_O, Done_O;
    logic [31:0] Hi_O, Lo_O;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk_I(clk), .rst_I(rst_I), .Start_I(Start_I), .Func_I(Func_I),
        .A_I(A_I), .B_I(B_I), .Busy_O(Busy_O), .Stall_O(Stall_O),
        .Done_O(Done_O), .Hi_O(Hi_O), .Lo_O(Lo_O)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
    // the remainder follows the dividend, matching MIPS semantics.
    function automatic logic [63:0] ref_hilo(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            FUNC_MULT:  begin q = sa * sb; return q; end
            FUNC_MULTU: begin p = ua * ub; return p; end
            FUNC_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one mul/div, wait (bounded) for Done_O, check latency, busy span, result, pulse width.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int lat, bcyc;
        @(negedge clk);
        Start_I = 1'b1; Func_I = f; A_I = a; B_I = b;
        @(negedge clk);
        Start_I = 1'b0; Func_I = FUNC_ADD;
        lat = 1; bcyc = 0;
        while (Done_O !== 1'b1 && lat < 200) begin
            if (Busy_O === 1'b1) bcyc++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 34);
        chk({tag, "_busy_cycles"}, bcyc, 33);
        chk({tag, "_busy_at_done"}, Busy_O, 0);
        chk({tag, "_hilo"}, {Hi_O, Lo_O}, exp);
        @(negedge clk);
        chk({tag, "_done_pulse"}, Done_O, 0);
    endtask

    initial begin
        logic [5:0]  ops [4];
        logic [5:0]  f;
        logic [31:0] a, b;
        logic [63:0] prev;
        int k, dones;
        ops[0] = FUNC_MULT; ops[1] = FUNC_MULTU; ops[2] = FUNC_DIV; ops[3] = FUNC_DIVU;

        rst_I = 1'b1; Start_I = 1'b0; Func_I = FUNC_ADD; A_I = '0; B_I = '0;
        repeat (3) @(negedge clk);
        rst_I = 1'b0;
        #1;
        chk("reset_hilo", {Hi_O, Lo_O}, 64'd0);
        chk("reset_busy", Busy_O, 0);
        chk("reset_done", Done_O, 0);
        chk("reset_stall", Stall_O, 0);

        // Directed cases from the plan plus the signed boundaries.
        run_op("mult_neg3x5", FUNC_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("divu_100_7", FUNC_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
        run_op("div_neg7_2", FUNC_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("divu_by0", FUNC_DIVU, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
        run_op("div_ovf", FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
        run_op("div_neg_by0", FUNC_DIV, 32'hFFFF_FFF6, 32'd0, {32'hFFFF_FFF6, 32'hFFFF_FFFF});
        run_op("mult_minsq", FUNC_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op("multu_max", FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

        // Randomized operations against the reference model.
        for (int i = 0; i < 12; i++) begin
            f = ops[$urandom_range(0, 3)];
            a = $urandom;
            b = (i % 5 == 4) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            run_op($sformatf("rand%0d", i), f, a, b, ref_hilo(f, a, b));
        end

        // MTHI/MTLO in idle: latency 1, other register untouched; MFHI has no effect.
        prev = {Hi_O, Lo_O};
        @(negedge clk);
        Start_I = 1'b1; Func_I = FUNC_MTLO; A_I = 32'hCAFE_0001;
        @(negedge clk);
        Start_I = 1'b1; Func_I = FUNC_MFHI; A_I = 32'hDEAD_BEEF;
        #1;
        chk("mtlo_value", {Hi_O, Lo_O}, {prev[63:32], 32'hCAFE_0001});
        chk("mfhi_no_stall", Stall_O, 0);
        @(negedge clk);
        Start_I = 1'b0;
        chk("mfhi_no_effect", {Hi_O, Lo_O}, {prev[63:32], 32'hCAFE_0001});
        chk("mfhi_not_busy", Busy_O, 0);

        // MULTU in flight, MTHI held under stall until IDLE.
        @(negedge clk);
        Start_I = 1'b1; Func_I = FUNC_MULTU; A_I = 32'hFFFF_FFFF; B_I = 32'd2;
        @(negedge clk);
        Func_I = FUNC_ADD; A_I = 32'h0000_1234;
        #1;
        chk("nonhilo_no_stall", Stall_O, 0);
        Func_I = FUNC_MTHI;
        #1;
        chk("hi_held_in_flight", Hi_O, prev[63:32]);
        k = 0;
        while (Stall_O === 1'b1 && k < 100) begin
            k++;
            @(negedge clk);
            #1;
        end
        chk("stall_cycles", k, 33);
        chk("stall_done", Done_O, 1);
        chk("stall_multu_hilo", {Hi_O, Lo_O}, ref_hilo(FUNC_MULTU, 32'hFFFF_FFFF, 32'd2));
        @(negedge clk);
        Start_I = 1'b0; Func_I = FUNC_ADD;
        #1;
        chk("mthi_after_stall", {Hi_O, Lo_O}, {32'h0000_1234, 32'hFFFF_FFFE});

        // Reset in the middle of RUN aborts with no Done_O pulse.
        @(negedge clk);
        Start_I = 1'b1; Func_I = FUNC_MULT; A_I = 32'd7; B_I = 32'd9;
        @(negedge clk);
        Start_I = 1'b0; Func_I = FUNC_ADD;
        repeat (9) @(negedge clk);
        chk("busy_before_reset", Busy_O, 1);
        #2 rst_I = 1'b1;
        #1;
        chk("reset_mid_busy", Busy_O, 0);
        chk("reset_mid_hilo", {Hi_O, Lo_O}, 64'd0);
        @(negedge clk);
        rst_I = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done_O === 1'b1) dones++;
        end
        chk("no_done_after_abort", dones, 0);
        chk("hilo_after_abort", {Hi_O, Lo_O}, 64'd0);
        run_op("mult_after_reset", FUNC_MULT, 32'd7, 32'hFFFF_FFF7, ref_hilo(FUNC_MULT, 32'd7, 32'hFFFF_FFF7));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
